// File: rtl/sam_dmem_pkg.sv
// Shared types and defaults for the sam_dmem_resp data-memory responder.
package sam_dmem_pkg;

    localparam int unsigned SAM_DMEM_DEPTH       = 32;
    localparam int unsigned SAM_DMEM_WAIT_CYCLES = 1;

    // Index width for a given word count; a single-word array still needs one bit.
    function automatic int unsigned sam_dmem_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned SAM_DMEM_IDX_W = sam_dmem_idx_w(SAM_DMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/sam_dmem_resp_if.sv
// Request/response handshake bundle between an initiator (master) and
// the data-memory responder (slave).
interface sam_dmem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sam_dmem_array.sv
// Word storage for sam_dmem_resp: synchronous write port and a registered
// read port. Storage is never reset; only the read register is.
module sam_dmem_array #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             RN,
    input  logic             we,
    input  logic             re,
    input  logic             clr,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Synchronous write; contents persist across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read; cleared for stores/errors so the response carries 0.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/sam_dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then holds the response until it is taken.
// Optional feature: define SAM_DMEM_RANGE_CHECK_EN to flag addr >= DEPTH
// as an error instead of wrapping the address.
module sam_dmem_resp
    import sam_dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = SAM_DMEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = SAM_DMEM_WAIT_CYCLES
) (
    input  logic             clk,
    input  logic             RN,
    sam_dmem_resp_if.slave   bus
);

    localparam int unsigned IDX_W = sam_dmem_idx_w(DEPTH);

    dmem_state_e      state_q, state_d;
    logic [3:0]       cnt_q;
    logic             rdy_q;
    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic             accept;
    logic             do_op;
    logic             op_ok;
    logic             arr_we;
    logic             arr_re;
    logic             arr_clr;

    assign accept = (state_q == IDLE) && rdy_q && bus.req_valid;
    assign do_op  = (state_q == BUSY) && (cnt_q == '0);

`ifdef SAM_DMEM_RANGE_CHECK_EN
    logic oor_q;
    logic err_q;

    // Range is judged at accept so the full address need not be kept.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            oor_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                oor_q <= (bus.req_addr >= DEPTH);
            end
            if (do_op) begin
                err_q <= oor_q;
            end
        end
    end

    assign op_ok       = !oor_q;
    assign bus.rsp_err = err_q;
`else
    logic unused_addr_hi;

    // Upper address bits are deliberately dropped: accesses wrap modulo 2**IDX_W.
    assign unused_addr_hi = ^bus.req_addr[31:IDX_W];
    assign op_ok          = 1'b1;
    assign bus.rsp_err    = 1'b0;
`endif

    assign arr_we  = do_op && we_q && op_ok;
    assign arr_re  = do_op && !we_q && op_ok;
    assign arr_clr = do_op && !arr_re;

    // Next-state: IDLE -> BUSY on accept, BUSY -> RESP when the wait count expires,
    // RESP -> IDLE when the response is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = BUSY;
            BUSY:    if (cnt_q == '0)   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // State, wait counter and captured request; req_ready is registered so it
    // stays low during reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            if (accept) begin
                cnt_q   <= 4'(WAIT_CYCLES);
                we_q    <= bus.req_we;
                idx_q   <= bus.req_addr[IDX_W-1:0];
                wdata_q <= bus.req_wdata;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = (state_q == RESP);

    sam_dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .RN    (RN),
        .we    (arr_we),
        .re    (arr_re),
        .clr   (arr_clr),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (bus.rsp_rdata)
    );

endmodule

// File: tb/tb_sam_dmem_resp.sv
// Directed bench for sam_dmem_resp: three instances with WAIT_CYCLES 1, 3, 0.
// Optional feature macro SAM_DMEM_RANGE_CHECK_EN selects the out-of-range expectations.
module tb_sam_dmem_resp;

    logic clk = 1'b0;
    logic RN  = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  rv  = '0;
    logic [2:0]  wen = '0;
    logic [2:0]  rr  = '0;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  err;
    logic [31:0] rdata [3];
    int unsigned wc [3] = '{1, 3, 0};

    int checks = 0;
    int errors = 0;

    sam_dmem_resp_if bus0 ();
    sam_dmem_resp_if bus1 ();
    sam_dmem_resp_if bus2 ();

    assign bus0.req_valid = rv[0];  assign bus0.req_we = wen[0];
    assign bus0.req_addr  = addr[0]; assign bus0.req_wdata = wdata[0];
    assign bus0.rsp_ready = rr[0];
    assign rdy[0] = bus0.req_ready; assign vld[0] = bus0.rsp_valid;
    assign err[0] = bus0.rsp_err;   assign rdata[0] = bus0.rsp_rdata;

    assign bus1.req_valid = rv[1];  assign bus1.req_we = wen[1];
    assign bus1.req_addr  = addr[1]; assign bus1.req_wdata = wdata[1];
    assign bus1.rsp_ready = rr[1];
    assign rdy[1] = bus1.req_ready; assign vld[1] = bus1.rsp_valid;
    assign err[1] = bus1.rsp_err;   assign rdata[1] = bus1.rsp_rdata;

    assign bus2.req_valid = rv[2];  assign bus2.req_we = wen[2];
    assign bus2.req_addr  = addr[2]; assign bus2.req_wdata = wdata[2];
    assign bus2.rsp_ready = rr[2];
    assign rdy[2] = bus2.req_ready; assign vld[2] = bus2.rsp_valid;
    assign err[2] = bus2.rsp_err;   assign rdata[2] = bus2.rsp_rdata;

    sam_dmem_resp #(.DEPTH(32), .WAIT_CYCLES(1)) u_dut_w1 (.clk(clk), .RN(RN), .bus(bus0));
    sam_dmem_resp #(.DEPTH(32), .WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .RN(RN), .bus(bus1));
    sam_dmem_resp #(.DEPTH(32), .WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .RN(RN), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        while (!rdy[d] && n < 40) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(rdy[d]), 1);
        rv[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
        tick();
        rv[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input int exp_lat);
        int lat = 0;
        while (!vld[d] && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_rsp(input int d);
        rr[d] = 1'b1;
        tick();
        rr[d] = 1'b0;
        check("rsp_valid_drop", 32'(vld[d]), 0);
        check("idle_ready", 32'(rdy[d]), 1);
    endtask

    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
        accept_req(d, w, a, wd);
        wait_rsp(d, int'(wc[d]) + 1);
        check("rsp_rdata", rdata[d], exp_rdata);
        check("rsp_err", 32'(err[d]), 32'(exp_err));
        finish_rsp(d);
    endtask

    initial begin
        int k, r, cyc, last;
        logic acc, hs;
        logic [31:0] hv;

        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wdata[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(rdy), 0);
        check("rst_rsp_valid", 32'(vld), 0);
        check("rst_rsp_err", 32'(err), 0);
        check("rst_rsp_rdata", rdata[0], 0);
        RN = 1'b1;
        #1;
        check("ready_before_edge", 32'(rdy), 0);
        tick();
        check("ready_after_edge", 32'(rdy), 3'b111);

        // Store then load, W=1
        xact(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Backpressure
        xact(0, 1'b1, 32'd2, 32'h0000_2222, 32'h0, 1'b0);
        accept_req(0, 1'b0, 32'd2, 32'h0);
        wait_rsp(0, 2);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(vld[0]), 1);
            check("bp_rdata", rdata[0], 32'h0000_2222);
            check("bp_ready", 32'(rdy[0]), 0);
            tick();
        end
        finish_rsp(0);

        // Inputs ignored while busy
        accept_req(0, 1'b0, 32'd5, 32'h0);
        rv[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'd2; wdata[0] = 32'h1234_5678;
        tick();
        addr[0] = 32'd9; wdata[0] = 32'h8765_4321; rv[0] = 1'b0; wen[0] = 1'b0;
        wait_rsp(0, 1);
        check("ign_rdata", rdata[0], 32'hDEAD_BEEF);
        finish_rsp(0);
        xact(0, 1'b0, 32'd2, 32'h0, 32'h0000_2222, 1'b0);

        // Out of range (40 wraps to 8 without the check)
        xact(0, 1'b1, 32'd8, 32'hAAAA_0008, 32'h0, 1'b0);
`ifdef SAM_DMEM_RANGE_CHECK_EN
        xact(0, 1'b1, 32'd40, 32'h1, 32'h0, 1'b1);
        xact(0, 1'b0, 32'd8, 32'h0, 32'hAAAA_0008, 1'b0);
`else
        xact(0, 1'b1, 32'd40, 32'h1, 32'h0, 1'b0);
        xact(0, 1'b0, 32'd8, 32'h0, 32'h1, 1'b0);
`endif

        // Reset mid-operation, W=3
        xact(1, 1'b1, 32'd3, 32'h0000_0033, 32'h0, 1'b0);
        accept_req(1, 1'b1, 32'd3, 32'h55);
        tick();
        #2;
        RN = 1'b0;
        #1;
        check("rst_mid_valid", 32'(vld[1]), 0);
        check("rst_mid_ready", 32'(rdy), 0);
        check("rst_mid_rdata", rdata[1], 0);
        repeat (2) tick();
        check("rst_hold_valid", 32'(vld[1]), 0);
        RN = 1'b1;
        tick();
        check("rst_rel_ready", 32'(rdy[1]), 1);
        xact(1, 1'b0, 32'd3, 32'h0, 32'h0000_0033, 1'b0);
        xact(0, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Back-to-back loads, W=0
        for (int i = 0; i < 4; i++) begin
            xact(2, 1'b1, 32'(10 + i), 32'hC0DE_000A + 32'(i), 32'h0, 1'b0);
        end
        rr[2] = 1'b1; rv[2] = 1'b1; wen[2] = 1'b0; addr[2] = 32'd10;
        k = 0; r = 0; cyc = 0; last = 0;
        while (r < 4 && cyc < 60) begin
            acc = rv[2] && rdy[2];
            hs  = vld[2] && rr[2];
            hv  = rdata[2];
            tick();
            cyc++;
            if (acc) begin
                if (k > 0) check("b2b_accept_gap", 32'(cyc - last), 3);
                last = cyc;
                k++;
                if (k == 4) rv[2] = 1'b0;
                else addr[2] = 32'(10 + k);
            end
            if (hs) begin
                check("b2b_rdata", hv, 32'hC0DE_000A + 32'(r));
                r++;
            end
        end
        rr[2] = 1'b0; rv[2] = 1'b0;
        check("b2b_rsp_count", 32'(r), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
